uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmit byte stream between `num_req_p` 32-bit AXI-Stream word requesters. Arbitration is round-robin at packet granularity (`tlast`): a granted requester keeps the transmitter until its `tlast` word has been fully serialized. Each accepted word is narrowed to bytes, least-significant byte first, honouring `tkeep`. The block sits between the 32-bit application streams and the 8-bit `s_axis` input of the `uart` core.

## Interface
- `num_req_p`, default 2: number of requesters, legal range 1..8.
- `clk_i` input 1: clock.
- `reset_i` input 1: reset, asynchronous, active-low.
- `s_tdata_i` input `num_req_p*32`: requester words; requester k uses bits `[32k+31:32k]`.
- `s_tkeep_i` input `num_req_p*4`: byte enables; requester k uses bits `[4k+3:4k]`.
- `s_tlast_i` input `num_req_p`: last word of the packet.
- `s_tvalid_i` input `num_req_p`: word valid.
- `s_tready_o` output `num_req_p`: word accepted when this and valid are both high.
- `m_tdata_o` output 8: byte to UART TX.
- `m_tvalid_o` output 1: byte valid.
- `m_tready_i` input 1: UART TX ready.
- `grant_o` output `num_req_p`: one-hot owner of the transmitter; all zero in IDLE.
- `busy_o` output 1: high whenever the state is not IDLE.

## Operation
- **States:**
  - IDLE: no owner.
  - SEND: serializing the held word.
  - HOLD: owner locked, waiting for its next word.
- **IDLE:**
  - If any `s_tvalid_i` is high, select the first valid requester searching upward from `ptr_r`, wrapping around.
  - Assert `s_tready_o` for that requester only, combinationally in the same cycle.
  - Capture data, keep and last into holding registers; record the owner `g`.
  - Next state is SEND.
- **SEND:**
  - Present the lowest-index kept byte not yet sent on `m_tdata_o`, with `m_tvalid_o` high.
  - On `m_tready_i`, advance to the next kept byte. Bytes with `tkeep=0` are skipped and take zero cycles.
  - After the final kept byte is accepted:
    - If the held last is 1: set `ptr_r` to `(g+1) mod num_req_p` and go to IDLE.
    - Otherwise go to HOLD.
- **Zero-keep word** (keep = 0000): the word is accepted and no byte is emitted. SEND exits on its first cycle, following the same last rule.
- **HOLD:**
  - `s_tready_o[g]` is high. All other readys are low, even if only other requesters are valid.
  - On a handshake from `g`, capture the word and go to SEND.
- `m_tdata_o` and `m_tvalid_o` must stay stable while `m_tvalid_o` is high and `m_tready_i` is low.
- **`num_req_p=1`:** the pointer is a constant 0 and the arbiter degenerates to a pass-through.

## Timing
- **Reset values:** `s_tready_o=0`, `m_tvalid_o=0`, `m_tdata_o=0`, `grant_o=0`, `busy_o=0`, `ptr_r=0`, state IDLE.
- **Reset mid-operation:** the in-flight word and any packet lock are discarded immediately and asynchronously; no partial byte is held.
- **Latency:** a word accepted in cycle N gives its first byte valid in cycle N+1.
- **Byte rate:** with `m_tready_i` held high, a 4-byte word occupies cycles N+1..N+4.
- **Word gap:** the next word is accepted no earlier than the cycle after the final byte handshake, giving one bubble between words.
- **`grant_o`:** updates one cycle after the IDLE capture and returns to zero one cycle after the final byte of a `tlast` word.
- **Simultaneous requests in IDLE:** exactly one ready is asserted.
- **Mid-packet arrivals:** a requester raising valid while another holds the grant waits; there is no preemption.

## Structure
- Package `uart_tx_arb_pkg`:
  - state enum `{IDLE, SEND, HOLD}`.
  - constants `word_width_lp=32`, `bytes_per_word_lp=4`, `byte_width_lp=8`.
- Sub-module `rr_arbiter`:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and its encoded index.
  - Purely combinational.
  - Reusable by other shared-resource blocks.
- Top level holds the state register, holding registers, byte-index counter and pointer.

## Test plan
- **Single word:** req0 sends `0xC0C0FFEE`, keep=1111, last=1, `m_tready_i` held high -> bytes EE, FF, C0, C0 in 4 consecutive cycles starting at N+1; `grant_o=01` during transfer, then 00.
- **Simultaneous requests, `num_req_p=2`:** both valid from reset, each sending one `tlast` word -> req0 served first, then req1; a second round serves req0 again.
- **Packet lock:** req1 sends 3 words (last only on word 3) while req0 is valid throughout -> all 12 bytes of req1 are emitted before any byte of req0; `s_tready_o[0]` stays low meanwhile.
- **Sparse keep:**
  - `0x00B835F2` with keep=0101 -> bytes F2, B8 only.
  - keep=0000, last=1 -> no bytes, returns to IDLE, pointer advances.
- **Backpressure:** `m_tready_i` toggles 1-0-0-1... -> `m_tdata_o` and `m_tvalid_o` are stable during stalls and no byte is duplicated or lost.
- **Reset during SEND:** drive `reset_i` low after byte 2 -> `m_tvalid_o` drops immediately; after release the state is IDLE and `ptr_r=0`.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
// Shared definitions for the UART transmit arbiter slice.
//   state_e            : arbiter FSM states (IDLE, SEND, HOLD)
//   word_width_lp      : width of one requester word (32)
//   bytes_per_word_lp  : bytes carried by one word (4)
//   byte_width_lp      : width of one UART byte (8)
//   idx_width()        : index width for a requester count, never below 1
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int word_width_lp     = 32;
    localparam int bytes_per_word_lp = 4;
    localparam int byte_width_lp     = 8;

    // A single requester still needs a 1-bit index so vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker for any shared resource.
// Searches upward from ptr_i (wrapping) for the first active request.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index the search starts from (highest priority this round)
//   gnt_o   : one-hot grant, all zero when nobody requests
//   idx_o   : encoded index of the granted requester
//   valid_o : high when some request was granted
module rr_arbiter #(
    parameter int num_req_p   = 2,
    parameter int idx_width_p = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic [num_req_p-1:0]   req_i,
    input  logic [idx_width_p-1:0] ptr_i,
    output logic [num_req_p-1:0]   gnt_o,
    output logic [idx_width_p-1:0] idx_o,
    output logic                   valid_o
);

    // Walk the requesters in priority order; the first hit wins and blocks
    // all later ones so the grant is always one-hot.
    always_comb begin
        int cand;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= num_req_p) begin
                cand = cand - num_req_p;
            end
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = idx_width_p'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one 8-bit UART transmit stream between num_req_p 32-bit
// AXI-Stream requesters. Ownership is round-robin per packet: the owner
// keeps the transmitter until its tlast word has been fully sent. Words are
// emitted least-significant kept byte first; unkept bytes cost no cycles.
//   clk_i, reset_i : clock, asynchronous active-low reset
//   s_tdata_i      : requester words, requester k at [32k+31:32k]
//   s_tkeep_i      : byte enables, requester k at [4k+3:4k]
//   s_tlast_i      : last word of packet, per requester
//   s_tvalid_i     : word valid, per requester
//   s_tready_o     : word accepted when ready and valid are both high
//   m_tdata_o      : byte towards UART TX
//   m_tvalid_o     : byte valid
//   m_tready_i     : UART TX ready
//   grant_o        : one-hot current owner, zero when idle
//   busy_o         : high whenever the FSM is not idle
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int num_req_p = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [num_req_p*32-1:0]  s_tdata_i,
    input  logic [num_req_p*4-1:0]   s_tkeep_i,
    input  logic [num_req_p-1:0]     s_tlast_i,
    input  logic [num_req_p-1:0]     s_tvalid_i,
    output logic [num_req_p-1:0]     s_tready_o,
    output logic [7:0]               m_tdata_o,
    output logic                     m_tvalid_o,
    input  logic                     m_tready_i,
    output logic [num_req_p-1:0]     grant_o,
    output logic                     busy_o
);

    localparam int idx_w_lp = idx_width(num_req_p);

    state_e                         state_q, state_d;
    logic [idx_w_lp-1:0]            owner_q, owner_d;
    logic [idx_w_lp-1:0]            ptr_q, ptr_d;
    logic [word_width_lp-1:0]       data_q, data_d;
    logic [bytes_per_word_lp-1:0]   keep_q, keep_d;
    logic                           last_q, last_d;

    logic [num_req_p-1:0]           arbGnt;
    logic [idx_w_lp-1:0]            arbIdx;
    logic                           arbValid;

    logic [idx_w_lp-1:0]            selIdx;
    logic [word_width_lp-1:0]       selData;
    logic [bytes_per_word_lp-1:0]   selKeep;
    logic                           selLast;
    logic                           selValid;

    logic [num_req_p-1:0]           ownerOneHot;
    logic [1:0]                     byteSel;
    logic [bytes_per_word_lp-1:0]   keepLeft;
    logic [idx_w_lp-1:0]            ptrNext;

    rr_arbiter #(
        .num_req_p   (num_req_p),
        .idx_width_p (idx_w_lp)
    ) u_rr_arbiter (
        .req_i   (s_tvalid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arbGnt),
        .idx_o   (arbIdx),
        .valid_o (arbValid)
    );

    // While idle the arbiter's choice is the word source; once a packet is
    // locked only the owner's stream is ever looked at.
    always_comb begin
        selIdx   = (state_q == IDLE) ? arbIdx : owner_q;
        selData  = '0;
        selKeep  = '0;
        selLast  = 1'b0;
        selValid = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            if (selIdx == idx_w_lp'(k)) begin
                selData  = s_tdata_i[k*word_width_lp +: word_width_lp];
                selKeep  = s_tkeep_i[k*bytes_per_word_lp +: bytes_per_word_lp];
                selLast  = s_tlast_i[k];
                selValid = s_tvalid_i[k];
            end
        end
    end

    // keep_q doubles as the "bytes still to send" mask: each accepted byte
    // clears its bit, so the lowest set bit is always the next byte out.
    always_comb begin
        byteSel = '0;
        for (int b = bytes_per_word_lp - 1; b >= 0; b--) begin
            if (keep_q[b]) begin
                byteSel = 2'(b);
            end
        end
        keepLeft = keep_q & ~(bytes_per_word_lp'(1) << byteSel);
    end

    // Owner decode feeds both the visible grant and the HOLD-state ready.
    always_comb begin
        ownerOneHot = '0;
        for (int k = 0; k < num_req_p; k++) begin
            ownerOneHot[k] = (owner_q == idx_w_lp'(k));
        end
        busy_o  = (state_q != IDLE);
        grant_o = busy_o ? ownerOneHot : '0;
        ptrNext = (int'(owner_q) == num_req_p - 1) ? '0 : owner_q + idx_w_lp'(1);
    end

    // Next-state and output logic. Ready in IDLE is gated by reset so that
    // nothing is offered while the block is held in reset.
    always_comb begin
        logic wordDone;
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        s_tready_o = '0;
        m_tvalid_o = 1'b0;
        m_tdata_o  = '0;
        wordDone   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (reset_i && arbValid) begin
                    s_tready_o = arbGnt;
                    data_d     = selData;
                    keep_d     = selKeep;
                    last_d     = selLast;
                    owner_d    = arbIdx;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (keep_q == '0) begin
                    wordDone = 1'b1;
                end else begin
                    m_tvalid_o = 1'b1;
                    m_tdata_o  = data_q[{byteSel, 3'b000} +: byte_width_lp];
                    if (m_tready_i) begin
                        keep_d   = keepLeft;
                        wordDone = (keepLeft == '0);
                    end
                end
                if (wordDone) begin
                    if (last_q) begin
                        ptr_d   = ptrNext;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                s_tready_o = ownerOneHot;
                if (selValid) begin
                    data_d  = selData;
                    keep_d  = selKeep;
                    last_d  = selLast;
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and holding registers; reset discards any word or packet lock.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with two requesters. Expected
// bytes (and their owning requester) are queued when words are driven and
// popped as the transmitter hands bytes over.
module tb_uart_tx_arbiter;

    localparam int nReq = 2;

    typedef struct {
        logic [7:0] data;
        int         req;
    } exp_t;

    typedef struct {
        int          req;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          expCount;
        logic [31:0] expBytes;
    } vec_t;

    logic                 clk;
    logic                 rstN;
    logic [nReq*32-1:0]   sTdata;
    logic [nReq*4-1:0]    sTkeep;
    logic [nReq-1:0]      sTlast;
    logic [nReq-1:0]      sTvalid;
    logic [nReq-1:0]      sTready;
    logic [7:0]           mTdata;
    logic                 mTvalid;
    logic                 mTready;
    logic [nReq-1:0]      grant;
    logic                 busy;

    exp_t sbq[$];
    int   byteCycles[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    int   lockViol = 0;
    logic prevStall = 1'b0;
    logic [7:0] prevData = '0;
    vec_t vecs[5];

    uart_tx_arbiter #(.num_req_p(nReq)) dut (
        .clk_i      (clk),
        .reset_i    (rstN),
        .s_tdata_i  (sTdata),
        .s_tkeep_i  (sTkeep),
        .s_tlast_i  (sTlast),
        .s_tvalid_i (sTvalid),
        .s_tready_o (sTready),
        .m_tdata_o  (mTdata),
        .m_tvalid_o (mTvalid),
        .m_tready_i (mTready),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    // Free-running clock and a cycle index used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Hard stop so a wedged design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void pushWord(input int req, input logic [31:0] d, input logic [3:0] k);
        for (int b = 0; b < 4; b++) begin
            if (k[b]) sbq.push_back('{d[b*8 +: 8], req});
        end
    endfunction

    // Present one word on requester req and hold it until accepted.
    task automatic applyStimulus(input int req, input logic [31:0] d, input logic [3:0] k,
                                 input logic l, output int acc);
        acc = -1;
        sTdata[req*32 +: 32] = d;
        sTkeep[req*4 +: 4]   = k;
        sTlast[req]          = l;
        sTvalid[req]         = 1'b1;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (sTready[req]) begin
                acc = cycleCnt;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        sTvalid[req] = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: requester %0d word never accepted, got none, expected handshake", req);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout: got %0d bytes outstanding, expected 0", sbq.size());
        end
    endtask

    // Output monitor: scoreboard pop on every byte handshake, stall
    // stability, single-ready and packet-lock observations.
    always begin
        @(negedge clk);
        #2;
        if (!rstN) begin
            prevStall = 1'b0;
        end else begin
            checkOutput("readyOneHot", 32'($countones(sTready) <= 1), 32'd1);
            if (grant[1] && sTready[0]) lockViol++;
            if (prevStall) begin
                checkOutput("stallValid", 32'(mTvalid), 32'd1);
                checkOutput("stallData", 32'(mTdata), 32'(prevData));
            end
            if (mTvalid && mTready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedByte: got %h, expected no byte", mTdata);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("byteData", 32'(mTdata), 32'(e.data));
                    checkOutput("byteGrant", 32'(grant), 32'(2'b01 << e.req));
                end
                byteCycles.push_back(cycleCnt);
            end
            prevStall = mTvalid && !mTready;
            prevData  = mTdata;
        end
    end

    initial begin
        int a0, a1, acc;
        bit done;

        vecs[0] = '{0, 32'hC0C0FFEE, 4'b1111, 1'b1, 4, 32'hC0C0FFEE};
        vecs[1] = '{1, 32'h00B835F2, 4'b0101, 1'b1, 2, 32'h0000B8F2};
        vecs[2] = '{0, 32'hA1B2C3D4, 4'b1000, 1'b1, 1, 32'h000000A1};
        vecs[3] = '{1, 32'h11223344, 4'b0110, 1'b1, 2, 32'h00002233};
        vecs[4] = '{0, 32'hDEADBEEF, 4'b0000, 1'b1, 0, 32'h00000000};

        // Reset values, with both requesters valid to show no ready leaks.
        rstN    = 1'b0;
        sTdata  = '0;
        sTkeep  = '1;
        sTlast  = '1;
        sTvalid = 2'b11;
        mTready = 1'b1;
        #7;
        checkOutput("rstReady", 32'(sTready), 32'd0);
        checkOutput("rstMvalid", 32'(mTvalid), 32'd0);
        checkOutput("rstMdata", 32'(mTdata), 32'd0);
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        @(negedge clk);
        sTvalid = '0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Both valid from reset: req0, req1, then req0, req1 again.
        $display("[TB] simultaneous requests, two rounds");
        pushWord(0, 32'h03020100, 4'b1111);
        pushWord(1, 32'h13121110, 4'b1111);
        pushWord(0, 32'h07060504, 4'b1111);
        pushWord(1, 32'h17161514, 4'b1111);
        fork
            begin
                applyStimulus(0, 32'h03020100, 4'b1111, 1'b1, a0);
                applyStimulus(0, 32'h07060504, 4'b1111, 1'b1, a0);
            end
            begin
                applyStimulus(1, 32'h13121110, 4'b1111, 1'b1, a1);
                applyStimulus(1, 32'h17161514, 4'b1111, 1'b1, a1);
            end
        join
        waitDrain(100);
        @(negedge clk);
        @(negedge clk);

        // Single word latency and grant timing.
        $display("[TB] single word timing");
        byteCycles.delete();
        pushWord(0, 32'hC0C0FFEE, 4'b1111);
        applyStimulus(0, 32'hC0C0FFEE, 4'b1111, 1'b1, acc);
        checkOutput("grantDuring", 32'(grant), 32'd1);
        waitDrain(50);
        @(negedge clk);
        checkOutput("firstByteCycle", 32'(byteCycles[0]), 32'(acc + 1));
        checkOutput("lastByteCycle", 32'(byteCycles[3]), 32'(acc + 4));
        checkOutput("grantAfter", 32'(grant), 32'd0);
        checkOutput("busyAfter", 32'(busy), 32'd0);

        // Table of single-word packets including sparse and zero keep.
        $display("[TB] vector table");
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].expCount; i++) begin
                logic [31:0] eb;
                eb = vecs[v].expBytes;
                sbq.push_back('{eb[i*8 +: 8], vecs[v].req});
            end
            applyStimulus(vecs[v].req, vecs[v].data, vecs[v].keep, vecs[v].last, acc);
            waitDrain(50);
            @(negedge clk);
            @(negedge clk);
            checkOutput($sformatf("vec%0dBusy", v), 32'(busy), 32'd0);
            checkOutput($sformatf("vec%0dGrant", v), 32'(grant), 32'd0);
        end

        // Zero-keep word from req0 moved the pointer to req1.
        $display("[TB] pointer advance after zero-keep");
        pushWord(1, 32'h2B2A2928, 4'b1111);
        pushWord(0, 32'h3B3A3938, 4'b1111);
        fork
            applyStimulus(0, 32'h3B3A3938, 4'b1111, 1'b1, a0);
            applyStimulus(1, 32'h2B2A2928, 4'b1111, 1'b1, a1);
        join
        waitDrain(50);
        @(negedge clk);

        // Packet lock: req1 three-word packet while req0 waits.
        $display("[TB] packet lock");
        lockViol = 0;
        pushWord(1, 32'h43424140, 4'b1111);
        pushWord(1, 32'h47464544, 4'b1111);
        pushWord(1, 32'h4B4A4948, 4'b1111);
        pushWord(0, 32'h53525150, 4'b1111);
        fork
            begin
                applyStimulus(1, 32'h43424140, 4'b1111, 1'b0, a1);
                applyStimulus(1, 32'h47464544, 4'b1111, 1'b0, a1);
                applyStimulus(1, 32'h4B4A4948, 4'b1111, 1'b1, a1);
            end
            applyStimulus(0, 32'h53525150, 4'b1111, 1'b1, a0);
        join
        waitDrain(100);
        checkOutput("lockNoReady0", 32'(lockViol), 32'd0);
        @(negedge clk);

        // Backpressure 1-0-0 repeating across a two-word packet.
        $display("[TB] backpressure");
        pushWord(0, 32'h63626160, 4'b1111);
        pushWord(0, 32'h67666564, 4'b1011);
        done = 1'b0;
        fork
            begin
                applyStimulus(0, 32'h63626160, 4'b1111, 1'b0, a0);
                applyStimulus(0, 32'h67666564, 4'b1011, 1'b1, a0);
                waitDrain(200);
                done = 1'b1;
            end
            begin
                for (int p = 0; p < 300 && !done; p++) begin
                    mTready = (p % 3 == 0);
                    @(negedge clk);
                end
            end
        join
        mTready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bpBusy", 32'(busy), 32'd0);

        // Reset during SEND after the second byte.
        $display("[TB] reset mid-word");
        pushWord(1, 32'h00007170, 4'b0011);
        applyStimulus(1, 32'h73727170, 4'b1111, 1'b1, a1);
        waitDrain(50);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midRstMvalid", 32'(mTvalid), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstGrant", 32'(grant), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        pushWord(0, 32'h83828180, 4'b1111);
        pushWord(1, 32'h93929190, 4'b1111);
        fork
            applyStimulus(0, 32'h83828180, 4'b1111, 1'b1, a0);
            applyStimulus(1, 32'h93929190, 4'b1111, 1'b1, a1);
        join
        waitDrain(50);
        @(negedge clk);
        @(negedge clk);
        checkOutput("finalQueue", 32'(sbq.size()), 32'd0);
        checkOutput("finalBusy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
